// File: rtl/alu_seg_scan.sv
// alu_seg_scan: registered 2-operand ALU whose result is shown in hex on a
// time-multiplexed 7-segment display. A free-running prescaler steps the digit
// index; seg/an are registered from the current index and result register.
module alu_seg_scan #(
   parameter int unsigned N        = 8,
   parameter int unsigned DIGITS   = 2,
   parameter int unsigned SCAN_DIV = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N-1:0]      A,
   input  logic [N-1:0]      B,
   input  logic [1:0]        OP,
   input  logic              LOAD,
   input  logic              EN,
   input  logic              BLANK,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] an,
   output logic [N-1:0]      result,
   output logic              flag
);

   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned NW = 4 * DIGITS;

   typedef enum logic [1:0] {
      OpAdd = 2'b00,
      OpSub = 2'b01,
      OpAnd = 2'b10,
      OpOr  = 2'b11
   } op_e;

   // Hex digit to segments, bit6 = a ... bit0 = g, active-high.
   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] s;
      unique case (nib)
         4'h0:    s = 7'b1111110;
         4'h1:    s = 7'b0110000;
         4'h2:    s = 7'b1101101;
         4'h3:    s = 7'b1111001;
         4'h4:    s = 7'b0110011;
         4'h5:    s = 7'b1011011;
         4'h6:    s = 7'b1011111;
         4'h7:    s = 7'b1110000;
         4'h8:    s = 7'b1111111;
         4'h9:    s = 7'b1111011;
         4'hA:    s = 7'b1110111;
         4'hB:    s = 7'b0011111;
         4'hC:    s = 7'b1001110;
         4'hD:    s = 7'b0111101;
         4'hE:    s = 7'b1001111;
         default: s = 7'b1000111;
      endcase
      return s;
   endfunction

   logic [N-1:0]      result_q, result_d;
   logic              flag_q, flag_d;
   logic [6:0]        seg_q, seg_d;
   logic [DIGITS-1:0] an_q, an_d;
   logic [PW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;

   logic [N:0]        sum_ext;
   logic [N:0]        diff_ext;
   logic [N-1:0]      alu_res;
   logic              alu_flag;
   logic              wrap;
   logic [NW-1:0]     res_pad;
   logic [3:0]        nibble;
   logic              upper_nz;
   logic              blank;

   // One extra bit holds carry (add) or borrow (sub, set iff A < B unsigned).
   assign sum_ext  = {1'b0, A} + {1'b0, B};
   assign diff_ext = {1'b0, A} - {1'b0, B};

   // ALU operation select and capture on LOAD.
   always_comb begin
      alu_res  = '0;
      alu_flag = 1'b0;
      unique case (op_e'(OP))
         OpAdd: begin
            alu_res  = sum_ext[N-1:0];
            alu_flag = sum_ext[N];
         end
         OpSub: begin
            alu_res  = diff_ext[N-1:0];
            alu_flag = diff_ext[N];
         end
         OpAnd: alu_res = A & B;
         default: alu_res = A | B;
      endcase
      result_d = LOAD ? alu_res : result_q;
      flag_d   = LOAD ? alu_flag : flag_q;
   end

   // Prescaler wraps at SCAN_DIV-1; the wrapping edge steps the digit index.
   always_comb begin
      wrap  = (cnt_q == PW'(SCAN_DIV - 1));
      cnt_d = wrap ? '0 : cnt_q + PW'(1);
      idx_d = idx_q;
      if (wrap) begin
         idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end
   end

   // Digit decode: select nibble, apply leading-zero blanking, gate with EN.
   always_comb begin
      res_pad        = '0;
      res_pad[N-1:0] = result_q;
      nibble         = 4'h0;
      upper_nz       = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (IW'(i) == idx_q) begin
            nibble = res_pad[4*i +: 4];
         end
         // Any non-zero nibble at or above the current digit keeps it visible.
         if ((IW'(i) >= idx_q) && (res_pad[4*i +: 4] != 4'h0)) begin
            upper_nz = 1'b1;
         end
      end
      blank = BLANK && (idx_q != '0) && !upper_nz;
      seg_d = '0;
      an_d  = '0;
      if (EN) begin
         an_d  = DIGITS'(1) << idx_q;
         seg_d = blank ? 7'b0000000 : hex7(nibble);
      end
   end

   // State registers with synchronous reset overriding LOAD and EN.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
         flag_q   <= 1'b0;
         seg_q    <= '0;
         an_q     <= '0;
         cnt_q    <= '0;
         idx_q    <= '0;
      end else begin
         result_q <= result_d;
         flag_q   <= flag_d;
         seg_q    <= seg_d;
         an_q     <= an_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
      end
   end

   assign result = result_q;
   assign flag   = flag_q;
   assign seg    = seg_q;
   assign an     = an_q;

endmodule

// File: tb/tb_alu_seg_scan.sv
// Directed bench for alu_seg_scan with N=8, DIGITS=2, SCAN_DIV=4.
module tb_alu_seg_scan;

   localparam int unsigned N        = 8;
   localparam int unsigned DIGITS   = 2;
   localparam int unsigned SCAN_DIV = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      A;
   logic [N-1:0]      B;
   logic [1:0]        OP;
   logic              LOAD;
   logic              EN;
   logic              BLANK;
   logic [6:0]        seg;
   logic [DIGITS-1:0] an;
   logic [N-1:0]      result;
   logic              flag;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   alu_seg_scan #(
      .N        (N),
      .DIGITS   (DIGITS),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .A      (A),
      .B      (B),
      .OP     (OP),
      .LOAD   (LOAD),
      .EN     (EN),
      .BLANK  (BLANK),
      .seg    (seg),
      .an     (an),
      .result (result),
      .flag   (flag)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic load_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
      A    = a;
      B    = b;
      OP   = op;
      LOAD = 1'b1;
      tick();
      LOAD = 1'b0;
   endtask

   // Step until the wanted digit is on display (bounded), then check it.
   task automatic wait_digit(input int d, input string tag, input logic [6:0] exp_seg);
      logic [1:0] want;
      want = 2'(1 << d);
      for (int i = 0; i < 12 && an !== want; i++) tick();
      chk({tag, "_an"}, 32'(an), 32'(want));
      chk({tag, "_seg"}, 32'(seg), 32'(exp_seg));
   endtask

   initial begin
      rst = 1'b1; EN = 1'b1; LOAD = 1'b0; BLANK = 1'b0;
      A = '0; B = '0; OP = 2'b00;
      tick();
      tick();
      chk("rst_result", 32'(result), 32'h00);
      chk("rst_flag", 32'(flag), 32'h0);
      chk("rst_seg", 32'(seg), 32'h00);
      chk("rst_an", 32'(an), 32'h0);

      // Release: digit 0 first, digit 1 after four more edges.
      rst = 1'b0;
      tick();
      chk("rel_an", 32'(an), 32'h1);
      chk("rel_seg", 32'(seg), 32'(7'b1111110));
      repeat (3) tick();
      chk("rel_hold_an", 32'(an), 32'h1);
      tick();
      chk("rel_an10", 32'(an), 32'h2);
      chk("rel_seg10", 32'(seg), 32'(7'b1111110));

      load_op(8'h3C, 8'h05, 2'b00);
      chk("add_res", 32'(result), 32'h41);
      chk("add_flag", 32'(flag), 32'h0);
      tick();
      wait_digit(0, "add_d0", 7'b0110000);
      wait_digit(1, "add_d1", 7'b0110011);

      A = 8'hAA; B = 8'h55; OP = 2'b01;
      tick();
      chk("hold_res", 32'(result), 32'h41);

      load_op(8'hFF, 8'h02, 2'b00);
      chk("carry_res", 32'(result), 32'h01);
      chk("carry_flag", 32'(flag), 32'h1);

      load_op(8'h03, 8'h05, 2'b01);
      chk("borrow_res", 32'(result), 32'hFE);
      chk("borrow_flag", 32'(flag), 32'h1);
      tick();
      wait_digit(0, "sub_d0", 7'b1001111);
      wait_digit(1, "sub_d1", 7'b1000111);

      load_op(8'h05, 8'h03, 2'b01);
      chk("sub_res", 32'(result), 32'h02);
      chk("sub_flag", 32'(flag), 32'h0);
      load_op(8'h77, 8'h77, 2'b01);
      chk("subeq_res", 32'(result), 32'h00);
      chk("subeq_flag", 32'(flag), 32'h0);

      load_op(8'hF0, 8'h3C, 2'b10);
      chk("and_res", 32'(result), 32'h30);
      chk("and_flag", 32'(flag), 32'h0);
      load_op(8'hF0, 8'h3C, 2'b11);
      chk("or_res", 32'(result), 32'hFC);
      chk("or_flag", 32'(flag), 32'h0);

      // 04 - FF wraps to 05 with borrow set.
      load_op(8'h04, 8'hFF, 2'b01);
      chk("wrap_res", 32'(result), 32'h05);
      chk("wrap_flag", 32'(flag), 32'h1);
      BLANK = 1'b1;
      tick();
      wait_digit(1, "blank_d1", 7'b0000000);
      wait_digit(0, "blank_d0", 7'b1011011);
      BLANK = 1'b0;
      tick();
      wait_digit(1, "noblank_d1", 7'b1111110);

      // Mid-scan reset overrides a concurrent LOAD.
      tick();
      tick();
      rst = 1'b1; LOAD = 1'b1; A = 8'hFF; B = 8'hFF; OP = 2'b00;
      tick();
      LOAD = 1'b0;
      chk("mrst_result", 32'(result), 32'h00);
      chk("mrst_flag", 32'(flag), 32'h0);
      chk("mrst_seg", 32'(seg), 32'h00);
      chk("mrst_an", 32'(an), 32'h0);
      rst = 1'b0;
      tick();
      chk("mrst_k1_an", 32'(an), 32'h1);
      chk("mrst_k1_seg", 32'(seg), 32'(7'b1111110));
      // LOAD during scanning: 12 + 34 = 46.
      A = 8'h12; B = 8'h34; OP = 2'b00; LOAD = 1'b1;
      tick();
      LOAD = 1'b0;
      chk("scan_load_res", 32'(result), 32'h46);
      tick();
      tick();
      chk("mrst_k4_an", 32'(an), 32'h1);
      chk("mrst_k4_seg", 32'(seg), 32'(7'b1011111));

      // Display off for three edges while the index keeps running.
      EN = 1'b0;
      tick();
      chk("en0_seg", 32'(seg), 32'h00);
      chk("en0_an", 32'(an), 32'h0);
      tick();
      tick();
      chk("en0_k7_an", 32'(an), 32'h0);
      EN = 1'b1;
      tick();
      chk("en1_k8_an", 32'(an), 32'h2);
      chk("en1_k8_seg", 32'(seg), 32'(7'b0110011));
      tick();
      chk("en1_k9_an", 32'(an), 32'h1);
      chk("en1_k9_seg", 32'(seg), 32'(7'b1011111));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/alu_seg_scan.md
ALU_SEG_SCAN -- requirements
Module: alu_seg_scan

Interface
REQ-001 Parameter N, default 8, SHALL set the operand and result width (N >= 1).
REQ-002 Parameter DIGITS, default 2, SHALL set the number of display digits (4*DIGITS >= N).
REQ-003 Parameter SCAN_DIV, default 1000, SHALL set the clock cycles per digit (SCAN_DIV >= 1).
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-006 Port A, input, N bits, SHALL be operand A.
REQ-007 Port B, input, N bits, SHALL be operand B.
REQ-008 Port OP, input, 2 bits, SHALL select the operation: 00 add, 01 subtract (A-B), 10 AND, 11 OR.
REQ-009 Port LOAD, input, 1 bit, SHALL be the capture strobe, sampled each edge.
REQ-010 Port EN, input, 1 bit, SHALL be the display enable.
REQ-011 Port BLANK, input, 1 bit, SHALL enable leading-zero blanking.
REQ-012 Port seg, output, 7 bits, SHALL be the registered segment pattern, bit6=a to bit0=g, active-high.
REQ-013 Port an, output, DIGITS bits, SHALL be the registered one-hot digit select, active-high, bit i = digit i (digit 0 = least significant nibble).
REQ-014 Port result, output, N bits, SHALL be the registered ALU result.
REQ-015 Port flag, output, 1 bit, SHALL be the registered carry (add) or borrow (subtract); 0 for AND/OR.

Function
REQ-016 On an edge with LOAD=1, result SHALL take OP(A,B) modulo 2^N and flag SHALL update in the same edge; with LOAD=0 both SHALL hold.
REQ-017 Add: flag SHALL be bit N of A+B. Subtract: flag SHALL be 1 iff A < B (unsigned).
REQ-018 A prescaler SHALL count 0..SCAN_DIV-1 every cycle and wrap to 0; the edge on which it wraps SHALL advance the digit index by 1, from DIGITS-1 back to 0.
REQ-019 With SCAN_DIV=1, the digit index SHALL advance on every edge.
REQ-020 Nibble i SHALL be result[4i+3:4i]; bits at or above N SHALL read as 0.
REQ-021 Hex patterns: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-022 Every edge, an SHALL become one-hot on the current digit index and seg SHALL become the pattern of that digit's nibble, computed from the current result register (1-cycle latency from index or result change).
REQ-023 With BLANK=1, digit i > 0 SHALL show seg=0000000 (an still asserted) when nibbles i..DIGITS-1 are all zero; digit 0 SHALL never be blanked.
REQ-024 With EN=0, seg and an SHALL be 0 on the next edge; the prescaler, digit index, and LOAD capture SHALL keep running.
REQ-025 LOAD during scanning SHALL NOT disturb the prescaler or digit index.

Reset
REQ-026 When rst=1 on an edge: result=0, flag=0, seg=0, an=0, prescaler=0, and digit index=0; rst SHALL override LOAD and EN.
REQ-027 On the first edge after rst is released with EN=1, an SHALL be 1 (digit 0) and seg SHALL be 1111110.
REQ-028 rst asserted mid-scan SHALL restart the scan at digit 0 with a full SCAN_DIV period.

Verification (N=8, DIGITS=2, SCAN_DIV=4)
REQ-029 Hold rst for 2 edges -> result=00, flag=0, seg=0, an=00; after release with EN=1 -> an=01 and seg=1111110, an=10 after 4 more edges.
REQ-030 A=3C, B=05, OP=00, LOAD pulse -> result=41, flag=0; digit0 seg=0110000, digit1 seg=0110011.
REQ-031 A=FF, B=02, OP=00 -> result=01, flag=1; A=03, B=05, OP=01 -> result=FE, flag=1, digit0 seg=1001111, digit1 seg=1000111.
REQ-032 A=F0, B=3C, OP=10 -> result=30, flag=0; OP=11 -> result=FC, flag=0.
REQ-033 Result=05 with BLANK=1 -> digit1 seg=0000000 with an=10, digit0 seg=1011011; with BLANK=0, digit1 seg=1111110.
REQ-034 EN=0 for 3 edges mid-digit -> seg=0, an=0 one edge later; after EN=1, display resumes at the digit the free-running index has reached; rst mid-scan -> index 0, prescaler 0.
